seq_det_ctrl: RTL and testbench

//  Run-control and configuration block for the serial pattern detector datapath.
//  - Loads a programmable pattern (default 10101) with a length and an overlap mode.
//  - Arms a detection window of N valid input bits and emits a one-cycle match pulse per hit.
//  - Counts hits; raises a level irq at window end, held until acknowledged.

---
 rtl/seq_det_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_det_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Run-control and configuration for the serial pattern detector: programmable
// pattern/length/overlap, windowed runs, match pulse and count, level irq.
module seq_det_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             abort,
    input  logic             d_in,
    input  logic             d_valid,
    output logic             q_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_ack
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0]       PAT_MAX = 4'(PAT_W);
    localparam logic [3:0]       DEF_LEN = (PAT_W < 5) ? 4'(PAT_W) : 4'd5;
    localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(5'b10101);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_r;
    logic [3:0]       len_r;
    logic             ovl_r;
    logic [WIN_W-1:0] win_r;
    logic [PAT_W-1:0] hist;
    logic [3:0]       bits_seen;
    logic [WIN_W-1:0] win_cnt;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] len_mask;
    logic [3:0]       seen_next;
    logic             hit;
    logic             last_bit;
    logic             cfg_ok;

    always_comb begin
        hist_next = PAT_W'({hist, d_in});
        len_mask  = '0;
        for (int i = 0; i < PAT_W; i++) len_mask[i] = (4'(i) < len_r);
        seen_next = (bits_seen == PAT_MAX) ? bits_seen : bits_seen + 4'd1;
        hit       = (seen_next >= len_r) && (((hist_next ^ pat_r) & len_mask) == '0);
        last_bit  = (win_r != '0) && (win_cnt == WIN_W'(1));
        cfg_ok    = (cfg_len != 4'd0) && (cfg_len <= PAT_MAX);
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pat_r     <= DEF_PAT;
            len_r     <= DEF_LEN;
            ovl_r     <= 1'b1;
            win_r     <= '0;
            hist      <= '0;
            bits_seen <= '0;
            win_cnt   <= '0;
            match_cnt <= '0;
            q_out     <= 1'b0;
            cfg_err   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            q_out   <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (state == S_IDLE && cfg_ok) begin
                    pat_r <= cfg_pattern;
                    len_r <= cfg_len;
                    ovl_r <= cfg_overlap;
                    win_r <= cfg_window;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        hist      <= '0;
                        bits_seen <= '0;
                        match_cnt <= '0;
                        win_cnt   <= win_r;
                    end
                end
                S_RUN: begin
                    // Abort beats everything, including a final window bit.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (d_valid) begin
                        if (hit) begin
                            q_out <= 1'b1;
                            if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
                        end
                        if (hit && !ovl_r) begin
                            hist      <= '0;
                            bits_seen <= '0;
                        end else begin
                            hist      <= hist_next;
                            bits_seen <= seen_next;
                        end
                        if (win_r != '0) win_cnt <= win_cnt - 1'b1;
                        if (last_bit) begin
                            state <= S_DONE;
                            irq   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (irq_ack && irq) begin
                        irq   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl; a second instance with CNT_W=2 covers
// match counter saturation.
module tb_seq_det_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [15:0] cfg_window = '0;
    logic       start = 1'b0, abort = 1'b0, d_in = 1'b0, d_valid = 1'b0, irq_ack = 1'b0;

    logic       q_out, busy, done, cfg_err, irq;
    logic [7:0] match_cnt;
    logic       q_out2, busy2, done2, cfg_err2, irq2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.PAT_W(5), .CNT_W(8), .WIN_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .start(start), .abort(abort), .d_in(d_in), .d_valid(d_valid),
        .q_out(q_out), .busy(busy), .done(done), .cfg_err(cfg_err),
        .match_cnt(match_cnt), .irq(irq), .irq_ack(irq_ack));

    seq_det_ctrl #(.PAT_W(5), .CNT_W(2), .WIN_W(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
        .start(start), .abort(abort), .d_in(d_in), .d_valid(d_valid),
        .q_out(q_out2), .busy(busy2), .done(done2), .cfg_err(cfg_err2),
        .match_cnt(match_cnt2), .irq(irq2), .irq_ack(irq_ack));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [4:0] p, input logic [3:0] l, input logic o,
                           input logic [15:0] w);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_window = w; cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic send(input logic b, input logic expq, input string tag);
        d_in = b; d_valid = 1'b1;
        cyc();
        d_valid = 1'b0;
        chk(tag, 32'(q_out), 32'(expq));
    endtask

    logic [6:0] s1;
    logic [6:0] q1;

    initial begin
        // reset
        cyc(); cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_q", 32'(q_out), 0);
        reset_n = 1'b1;
        cyc(); cyc(); cyc();

        // 1: defaults, window 7, stream 1010101, with an idle gap after bit 3
        set_cfg(5'b10101, 4'd5, 1'b1, 16'd7);
        do_start();
        chk("t1_busy", 32'(busy), 1);
        s1 = 7'b1010101; q1 = 7'b0000101;
        for (int i = 6; i >= 0; i--) begin
            send(s1[i], q1[i], "t1_q");
            if (i == 4) begin
                cyc();
                chk("t1_gap_busy", 32'(busy), 1);
            end
        end
        chk("t1_cnt", 32'(match_cnt), 2);
        chk("t1_irq", 32'(irq), 1);
        chk("t1_done", 32'(done), 1);
        cyc();
        chk("t1_irq_held", 32'(irq), 1);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("t1_ack_irq", 32'(irq), 0);
        chk("t1_ack_done", 32'(done), 0);
        chk("t1_ack_cnt", 32'(match_cnt), 2);

        // 2: no overlap
        set_cfg(5'b10101, 4'd5, 1'b0, 16'd7);
        do_start();
        q1 = 7'b0000100;
        for (int i = 6; i >= 0; i--) send(s1[i], q1[i], "t2_q");
        chk("t2_cnt", 32'(match_cnt), 1);
        chk("t2_done", 32'(done), 1);
        chk("t2_irq", 32'(irq), 1);
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;

        // 3: 1101, unlimited window, abort
        set_cfg(5'b01101, 4'd4, 1'b1, 16'd0);
        do_start();
        s1 = 7'b1101101; q1 = 7'b0001001;
        for (int i = 6; i >= 0; i--) send(s1[i], q1[i], "t3_q");
        chk("t3_cnt", 32'(match_cnt), 2);
        do_abort();
        chk("t3_busy", 32'(busy), 0);
        chk("t3_irq", 32'(irq), 0);
        chk("t3_cnt_kept", 32'(match_cnt), 2);

        // 4: rejected config writes
        set_cfg(5'b10101, 4'd0, 1'b0, 16'd3);
        chk("t4_err_len0", 32'(cfg_err), 1);
        cyc();
        chk("t4_err_clr", 32'(cfg_err), 0);
        set_cfg(5'b10101, 4'd6, 1'b0, 16'd3);
        chk("t4_err_len6", 32'(cfg_err), 1);
        do_start();
        s1 = 7'b1101101; q1 = 7'b0001001;
        for (int i = 6; i >= 4; i--) send(s1[i], q1[i], "t4_q");
        set_cfg(5'b10101, 4'd5, 1'b0, 16'd3);
        chk("t4_err_run", 32'(cfg_err), 1);
        chk("t4_busy", 32'(busy), 1);
        for (int i = 3; i >= 0; i--) send(s1[i], q1[i], "t4_q");
        chk("t4_cnt", 32'(match_cnt), 2);
        do_abort();

        // 5: counter saturation on the CNT_W=2 instance
        set_cfg(5'b00001, 4'd1, 1'b1, 16'd0);
        do_start();
        for (int i = 0; i < 15; i++) send(1'b1, 1'b1, "t5_q");
        chk("t5_cnt8", 32'(match_cnt), 15);
        chk("t5_cnt2", 32'(match_cnt2), 3);
        do_abort();

        // start and abort together from IDLE: start wins
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 1);
        do_abort();
        chk("sa_abort", 32'(busy), 0);

        // 6: reset mid-run, then defaults need five fresh bits
        set_cfg(5'b00101, 4'd3, 1'b0, 16'd4);
        do_start();
        send(1'b1, 1'b0, "t6_q");
        send(1'b0, 1'b0, "t6_q");
        send(1'b1, 1'b1, "t6_q");
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_q", 32'(q_out), 0);
        chk("t6_rst_cnt", 32'(match_cnt), 0);
        chk("t6_rst_irq", 32'(irq), 0);
        #1 reset_n = 1'b1;
        cyc(); cyc(); cyc();
        do_start();
        s1 = 7'b0010101; q1 = 7'b0000001;
        for (int i = 4; i >= 0; i--) send(s1[i], q1[i], "t6_q");
        chk("t6_cnt", 32'(match_cnt), 1);
        chk("t6_busy", 32'(busy), 1);
        do_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
